// File: rtl/wen_burst_pkg.sv
// Shared types and helpers for the word-enable burst decoder.
// Optional checker macro used by the top level: WEN_BURST_ONEHOT_CHK_EN.
package wen_burst_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Widest enable vector the helpers support (ADDR_W up to 7).
  localparam int unsigned MAX_WEN = 256;

  // One-hot decode of a binary address; out-of-range addresses give zero.
  function automatic logic [MAX_WEN-1:0] onehot_dec(input int unsigned addr);
    logic [MAX_WEN-1:0] v;
    v = '0;
    if (addr < MAX_WEN) v[addr[7:0]] = 1'b1;
    return v;
  endfunction

  // Advance an address by one, wrapping at the last implemented word.
  function automatic int unsigned next_addr(input int unsigned addr,
                                            input int unsigned depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/wen_onehot_dec.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder. Output is zero
// unless enabled and the address falls inside the implemented DEPTH words.
module wen_onehot_dec
  import wen_burst_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] wen
);

  localparam int WEN_W = 2**ADDR_W;

  logic [MAX_WEN-1:0] full;
  logic               in_range;
  logic               unused_hi;

  // Decode through the shared helper and gate with enable and range.
  always_comb begin
    full      = onehot_dec(32'(addr));
    in_range  = 32'(addr) < 32'(DEPTH);
    wen       = (en && in_range) ? full[WEN_W-1:0] : '0;
    unused_hi = ^full[MAX_WEN-1:WEN_W];
  end

endmodule

// File: rtl/wen_burst_decoder.sv
// Burst word-enable decoder: accepts (addr, len) commands and emits one
// registered one-hot word enable per beat, wrapping at DEPTH-1.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised by this block, stays up with stable
// data until the transfer (or an abort/reset) takes place.
// Optional feature macro: WEN_BURST_ONEHOT_CHK_EN (sticky onehot_err output
// plus a simulation assertion on the registered wen invariant).
module wen_burst_decoder
  import wen_burst_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 abort,
  output logic [2**ADDR_W-1:0] wen,
  output logic                 wen_valid,
  input  logic                 wen_ready,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err,
`ifdef WEN_BURST_ONEHOT_CHK_EN
  output logic                 onehot_err,
`endif
  output state_t               dbg_state
);

  localparam int WEN_W = 2**ADDR_W;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [LEN_W-1:0]    rem_q, rem_nxt;
  logic                done_nxt, err_nxt, active_nxt;
  logic [WEN_W-1:0]    wen_nxt;
  logic                bad_cmd;

  assign dbg_state = state;
  assign cmd_ready = rst_n && (state == IDLE);
  assign bad_cmd   = ({1'b0, cmd_addr} >= (ADDR_W+1)'(DEPTH)) || (cmd_len == '0);

  // Next-state, next-address and pulse computation for the burst FSM.
  always_comb begin
    state_nxt = state;
    addr_nxt  = cur_addr;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = ACTIVE;
            addr_nxt  = cmd_addr;
            rem_nxt   = cmd_len;
          end
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
          rem_nxt   = '0;
        end else if (wen_ready) begin
          if (rem_q == LEN_W'(1)) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = ADDR_W'(next_addr(32'(cur_addr), 32'(DEPTH)));
            rem_nxt  = rem_q - LEN_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt == ACTIVE);
  end

  // The registered enable is decoded from the next-state address.
  wen_onehot_dec #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dec (
    .addr (addr_nxt),
    .en   (active_nxt),
    .wen  (wen_nxt)
  );

  // FSM state and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem_q     <= '0;
      wen       <= '0;
      wen_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= addr_nxt;
      rem_q     <= rem_nxt;
      wen       <= wen_nxt;
      wen_valid <= active_nxt;
      busy      <= active_nxt;
      done      <= done_nxt;
      cmd_err   <= err_nxt;
    end
  end

`ifdef WEN_BURST_ONEHOT_CHK_EN
  logic multi_hot, out_of_range, stray, chk_bad;

  // Invariant on the registered enable: one-hot or zero, in range, and
  // zero exactly when no beat is live.
  always_comb begin
    multi_hot    = |(wen & (wen - WEN_W'(1)));
    out_of_range = (wen >> DEPTH) != '0;
    stray        = !wen_valid && (wen != '0);
    chk_bad      = multi_hot || out_of_range || stray
                   || (wen_valid && (wen == '0));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_err <= 1'b0;
    else        onehot_err <= onehot_err | chk_bad;
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) !chk_bad);
`endif

endmodule

// File: tb/tb_wen_burst_decoder.sv
// Directed bench for wen_burst_decoder (ADDR_W=3, DEPTH=6, LEN_W=4).
module tb_wen_burst_decoder;
  import wen_burst_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       abort;
  logic [7:0] wen;
  logic       wen_valid;
  logic       wen_ready;
  logic [2:0] cur_addr;
  logic       busy;
  logic       done;
  logic       cmd_err;
`ifdef WEN_BURST_ONEHOT_CHK_EN
  logic       onehot_err;
`endif
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  wen_burst_decoder #(.ADDR_W(3), .DEPTH(6), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .wen        (wen),
    .wen_valid  (wen_valid),
    .wen_ready  (wen_ready),
    .cur_addr   (cur_addr),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err),
`ifdef WEN_BURST_ONEHOT_CHK_EN
    .onehot_err (onehot_err),
`endif
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge; returns just after that edge.
  task automatic send_cmd(input logic [2:0] a, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    abort = 1'b0; wen_ready = 1'b0;
    #12;
    check("rst_wen", 32'(wen), 32'h0);
    check("rst_wen_valid", 32'(wen_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_cur_addr", 32'(cur_addr), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 1: addr=2 len=3, always ready
    wen_ready = 1'b1;
    send_cmd(3'd2, 4'd3);
    check("t1_wen0", 32'(wen), 32'h04);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_cmd_ready_busy", 32'(cmd_ready), 32'h0);
    step();
    check("t1_wen1", 32'(wen), 32'h08);
    step();
    check("t1_wen2", 32'(wen), 32'h10);
    check("t1_done_early", 32'(done), 32'h0);
    step();
    check("t1_done", 32'(done), 32'h1);
    check("t1_wen_idle", 32'(wen), 32'h0);
    check("t1_wen_valid_idle", 32'(wen_valid), 32'h0);
    check("t1_cmd_ready", 32'(cmd_ready), 32'h1);
    step();
    check("t1_done_pulse", 32'(done), 32'h0);

    // 2: wrap at DEPTH-1=5
    send_cmd(3'd4, 4'd4);
    check("t2_addr0", 32'(cur_addr), 32'd4);
    check("t2_wen0", 32'(wen), 32'h10);
    step();
    check("t2_addr1", 32'(cur_addr), 32'd5);
    check("t2_wen1", 32'(wen), 32'h20);
    step();
    check("t2_addr2", 32'(cur_addr), 32'd0);
    check("t2_wen2", 32'(wen), 32'h01);
    step();
    check("t2_addr3", 32'(cur_addr), 32'd1);
    check("t2_wen3", 32'(wen), 32'h02);
    step();
    check("t2_done", 32'(done), 32'h1);

    // 3: backpressure for three cycles
    wen_ready = 1'b0;
    send_cmd(3'd0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_wen", 32'(wen), 32'h01);
      check("t3_hold_addr", 32'(cur_addr), 32'd0);
      step();
    end
    check("t3_hold_last", 32'(wen), 32'h01);
    wen_ready = 1'b1;
    step();
    check("t3_beat2", 32'(wen), 32'h02);
    check("t3_no_done", 32'(done), 32'h0);
    step();
    check("t3_done", 32'(done), 32'h1);
    check("t3_wen_idle", 32'(wen), 32'h0);

    // 4: rejects, plus in-range boundary
    send_cmd(3'd7, 4'd3);
    check("t4_err_addr7", 32'(cmd_err), 32'h1);
    check("t4_busy_addr7", 32'(busy), 32'h0);
    check("t4_wen_addr7", 32'(wen), 32'h0);
    step();
    check("t4_err_pulse", 32'(cmd_err), 32'h0);
    send_cmd(3'd6, 4'd1);
    check("t4_err_addr6", 32'(cmd_err), 32'h1);
    send_cmd(3'd1, 4'd0);
    check("t4_err_len0", 32'(cmd_err), 32'h1);
    check("t4_wen_len0", 32'(wen), 32'h0);
    check("t4_valid_len0", 32'(wen_valid), 32'h0);
    send_cmd(3'd5, 4'd1);
    check("t4_addr5_ok", 32'(cmd_err), 32'h0);
    check("t4_addr5_wen", 32'(wen), 32'h20);
    step();
    check("t4_addr5_done", 32'(done), 32'h1);

    // 5: abort beats a firing beat on beat 2 of 5
    send_cmd(3'd0, 4'd5);
    check("t5_beat1", 32'(wen), 32'h01);
    step();
    check("t5_beat2", 32'(wen), 32'h02);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_wen", 32'(wen), 32'h0);
    check("t5_abort_valid", 32'(wen_valid), 32'h0);
    check("t5_abort_busy", 32'(busy), 32'h0);
    check("t5_abort_addr", 32'(cur_addr), 32'h0);
    check("t5_abort_done", 32'(done), 32'h0);
    check("t5_abort_ready", 32'(cmd_ready), 32'h1);
    step();
    check("t5_abort_done2", 32'(done), 32'h0);
    send_cmd(3'd1, 4'd1);
    check("t5_new_wen", 32'(wen), 32'h02);
    step();
    check("t5_new_done", 32'(done), 32'h1);
    check("t5_new_wen_idle", 32'(wen), 32'h0);
    // abort in IDLE does not block a command
    abort = 1'b1;
    send_cmd(3'd3, 4'd1);
    abort = 1'b0;
    check("t5_idle_abort_wen", 32'(wen), 32'h08);
    step();
    check("t5_idle_abort_done", 32'(done), 32'h1);

    // 6: reset in the middle of a burst
    send_cmd(3'd0, 4'd4);
    step();
    check("t6_pre_wen", 32'(wen), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_wen", 32'(wen), 32'h0);
    check("t6_rst_valid", 32'(wen_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_addr", 32'(cur_addr), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_err", 32'(cmd_err), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("t6_ready", 32'(cmd_ready), 32'h1);
    check("t6_done_after", 32'(done), 32'h0);
    check("t6_err_after", 32'(cmd_err), 32'h0);
`ifdef WEN_BURST_ONEHOT_CHK_EN
    check("t6_onehot_err", 32'(onehot_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
